// File: rtl/binncount_pkg.sv
// Shared constants for the binncount synchronous counter/divider family.
// Default geometry matches the original 3-bit divide-by-8 block.
package binncount_pkg;

   localparam int DEFAULT_WIDTH   = 3;
   localparam int DEFAULT_MODULUS = 8;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/binncount_tc.sv
// Combinational terminal-count detector: high in the cycle whose edge wraps the count.
// Its output drives both the TC port and the wrap/SQ-toggle decision in the top.
module binncount_tc
   import binncount_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int MODULUS = DEFAULT_MODULUS
) (
   input  logic [WIDTH-1:0] Q,
   input  logic             UP,
   input  logic             EN,
   input  logic             LOAD,
   output logic             TC
);

   // Compare against the last legal value, not all-ones, so odd moduli wrap exactly.
   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   logic w_at_end;

   assign w_at_end = (UP == DIR_UP) ? (Q == LAST) : (Q == '0);
   assign TC       = EN & ~LOAD & w_at_end;

endmodule

// File: rtl/binncount.sv
// Synchronous N-bit modulo counter / clock divider with up/down, enable, parallel
// load, terminal-count pulse for cascading and a divide-by-2*MODULUS square wave.
module binncount
   import binncount_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int MODULUS = DEFAULT_MODULUS
) (
   input  logic             IPTCLK,
   input  logic             IPTRSTN,
   input  logic             EN,
   input  logic             UP,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             SQ
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
      $error("binncount: WIDTH must be 1..16 and MODULUS 2..2**WIDTH");
   end

   logic [WIDTH-1:0] r_q;
   logic             r_sq;
   logic             w_tc;
   logic             w_d_in_range;
   logic [WIDTH-1:0] w_load_val;
   logic [WIDTH-1:0] w_step_val;

   binncount_tc #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_tc (
      .Q    (r_q),
      .UP   (UP),
      .EN   (EN),
      .LOAD (LOAD),
      .TC   (w_tc)
   );

   // Out-of-range load values clamp to the last legal count.
   assign w_d_in_range = (32'(D) < 32'(MODULUS));
   assign w_load_val   = w_d_in_range ? D : LAST;

   always_comb begin
      w_step_val = r_q;
      if (UP == DIR_UP) begin
         w_step_val = w_tc ? '0 : r_q + WIDTH'(1);
      end else begin
         w_step_val = w_tc ? LAST : r_q - WIDTH'(1);
      end
   end

   always_ff @(posedge IPTCLK) begin
      if (!IPTRSTN) begin
         r_q  <= '0;
         r_sq <= 1'b0;
      end else if (LOAD) begin
         r_q <= w_load_val;
      end else if (EN) begin
         r_q <= w_step_val;
         if (w_tc) begin
            r_sq <= ~r_sq;
         end
      end
   end

   assign Q  = r_q;
   assign SQ = r_sq;
   // Reset masks TC so a cascaded stage cannot advance while held in reset.
   assign TC = w_tc & IPTRSTN;

endmodule
